// File: rtl/uart_rx_robust.sv
// 8-bit UART receiver with a 2-flop synchroniser, 3-sample majority vote, and optional parity.
// Also detects framing errors and breaks, and presents bytes through a ready/valid holding register with overrun flag.
module uart_rx_robust #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_break,
  output logic       o_overrun,
  input  logic       i_clr_overrun,
  output logic       o_busy
);

  localparam int unsigned MID    = CLKS_PER_BIT / 2;
  localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_PRE  = 16'(MID - 1);
  localparam logic [15:0] C_MID  = 16'(MID);
  localparam logic [15:0] C_POST = 16'(MID + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta, rxs, rxd;
  logic [1:0]  sync_fill;
  logic        armed;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        samp_a, samp_b;
  logic        par_bit, par_err_q;
  logic        maj, fall, at_pre, at_mid, at_post, at_last;
  logic        frame_done, brk_w, load;

  assign at_pre     = (cnt == C_PRE);
  assign at_mid     = (cnt == C_MID);
  assign at_post    = (cnt == C_POST);
  assign at_last    = (cnt == C_LAST);
  assign maj        = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign fall       = armed & rxd & ~rxs;
  assign frame_done = (state_q == S_STOP) && at_post;
  assign brk_w      = ~maj && (shreg == 8'h00) && (!PARITY_EN || !par_bit);
  assign load       = frame_done && (!o_rx_valid || i_rx_ready);
  assign o_busy     = (state_q != S_IDLE);

  // Edge detection stays disarmed until the synchronised line has been seen high,
  // so a line held low through reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxd       <= 1'b1;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= i_rx_serial;
      rxs       <= rx_meta;
      rxd       <= rxs;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rxs);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (fall) state_d = S_START;
      S_START: begin
        if (at_post && maj) state_d = S_IDLE;
        else if (at_last)   state_d = S_DATA;
      end
      S_DATA:     if (at_last && bit_idx == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY:   if (at_last) state_d = S_STOP;
      S_STOP:     if (at_post) state_d = brk_w ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (rxs) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      par_bit   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE || state_q == S_BRK_WAIT || state_d != state_q || at_last)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (at_pre) samp_a <= rxs;
      if (at_mid) samp_b <= rxs;
      if (state_q == S_START) begin
        bit_idx   <= '0;
        par_bit   <= 1'b0;
        par_err_q <= 1'b0;
      end
      if (state_q == S_DATA && at_post) shreg   <= {maj, shreg[7:1]};
      if (state_q == S_DATA && at_last) bit_idx <= bit_idx + 3'd1;
      if (state_q == S_PARITY && at_post) begin
        par_bit   <= maj;
        par_err_q <= ((^shreg) ^ maj) != PARITY_ODD;
      end
    end
  end

  // A completing frame may load in the same cycle the held one is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (load) begin
        o_rx_data    <= shreg;
        o_frame_err  <= ~maj;
        o_parity_err <= par_err_q;
        o_break      <= brk_w;
        o_rx_valid   <= 1'b1;
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid   <= 1'b0;
      end
      if (frame_done && !load) o_overrun <= 1'b1;
      else if (i_clr_overrun)  o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_robust.sv
// Directed bench for uart_rx_robust: 8-N-1 instance and an even-parity instance, both at 16 clocks per bit.
module tb_uart_rx_robust;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx, ready, clr;
  logic [7:0] data;
  logic       valid, fe, pe, brk, ovr, busy;
  logic       rx_p, ready_p, clr_p;
  logic [7:0] data_p;
  logic       valid_p, fe_p, pe_p, brk_p, ovr_p, busy_p;

  uart_rx_robust #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx), .o_rx_data(data), .o_rx_valid(valid),
    .i_rx_ready(ready), .o_frame_err(fe), .o_parity_err(pe), .o_break(brk),
    .o_overrun(ovr), .i_clr_overrun(clr), .o_busy(busy)
  );

  uart_rx_robust #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_p), .o_rx_data(data_p), .o_rx_valid(valid_p),
    .i_rx_ready(ready_p), .o_frame_err(fe_p), .o_parity_err(pe_p), .o_break(brk_p),
    .o_overrun(ovr_p), .i_clr_overrun(clr_p), .o_busy(busy_p)
  );

  int         checks = 0, failures = 0;
  int         frames = 0, frames_p = 0;
  logic [7:0] cap_data = 8'h00, cap_data_p = 8'h00;
  logic       cap_fe = 0, cap_pe = 0, cap_brk = 0, cap_fe_p = 0, cap_pe_p = 0;
  logic       use_p = 0;

  always @(negedge clk) begin
    if (valid && ready) begin
      frames++;
      cap_data = data; cap_fe = fe; cap_pe = pe; cap_brk = brk;
    end
    if (valid_p && ready_p) begin
      frames_p++;
      cap_data_p = data_p; cap_fe_p = fe_p; cap_pe_p = pe_p;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic v);
    if (use_p) rx_p = v;
    else       rx   = v;
  endtask

  task automatic send_bit(input logic v, input int glitch_at);
    for (int i = 0; i < CPB; i++) begin
      set_line((i == glitch_at) ? ~v : v);
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                            input logic stop, input int glitch_bit);
    send_bit(1'b0, -1);
    for (int b = 0; b < 8; b++) send_bit(d[b], (b == glitch_bit) ? 9 : -1);
    if (par_en) send_bit(par, -1);
    send_bit(stop, -1);
    set_line(1'b1);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; rx = 0; rx_p = 1; ready = 1; clr = 0; ready_p = 1; clr_p = 0;
    repeat (3) tick();
    checks++;
    if ({valid, data, fe, pe, brk, ovr, busy} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {valid, data, fe, pe, brk, ovr, busy});
    end
    rst_n = 1;
    repeat (40) tick();
    checks++;
    if (busy !== 1'b0 || frames !== 0) begin
      failures++;
      $display("FAIL low_out_of_reset got busy=%b frames=%0d exp busy=0 frames=0", busy, frames);
    end
    rx = 1;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_release got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    int f0 = frames;
    send_frame(8'hA5, 0, 0, 1, -1);
    checks++;
    if (frames !== f0 + 1 || cap_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_a5 got frames=%0d data=%h exp frames=%0d data=a5", frames - f0, cap_data, 1);
    end
    checks++;
    if ({cap_fe, cap_pe, cap_brk, ovr, valid} !== 5'b0) begin
      failures++;
      $display("FAIL basic_flags got fe/pe/brk/ovr/valid=%b exp 00000", {cap_fe, cap_pe, cap_brk, ovr, valid});
    end
  endtask

  task automatic test_glitch();
    int f0 = frames;
    send_frame(8'h3C, 0, 0, 1, 2);
    checks++;
    if (frames !== f0 + 1 || cap_data !== 8'h3C) begin
      failures++;
      $display("FAIL glitch_3c got frames=%0d data=%h exp frames=1 data=3c", frames - f0, cap_data);
    end
    f0 = frames;
    rx = 0;
    repeat (3) tick();
    rx = 1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL false_start_busy got=%b exp 1", busy);
    end
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || frames !== f0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL false_start_idle got busy=%b frames=%0d valid=%b exp 0 0 0", busy, frames - f0, valid);
    end
  endtask

  task automatic test_parity();
    int f0 = frames_p;
    use_p = 1;
    send_frame(8'h07, 1, 1, 1, -1);
    checks++;
    if (frames_p !== f0 + 1 || cap_data_p !== 8'h07 || cap_pe_p !== 1'b0 || cap_fe_p !== 1'b0) begin
      failures++;
      $display("FAIL parity_good got frames=%0d data=%h pe=%b fe=%b exp 1 07 0 0", frames_p - f0, cap_data_p, cap_pe_p, cap_fe_p);
    end
    send_frame(8'h07, 1, 0, 1, -1);
    checks++;
    if (frames_p !== f0 + 2 || cap_data_p !== 8'h07 || cap_pe_p !== 1'b1 || cap_fe_p !== 1'b0) begin
      failures++;
      $display("FAIL parity_bad got frames=%0d data=%h pe=%b fe=%b exp 2 07 1 0", frames_p - f0, cap_data_p, cap_pe_p, cap_fe_p);
    end
    use_p = 0;
  endtask

  task automatic test_framing_break();
    int f0 = frames;
    send_frame(8'h55, 0, 0, 0, -1);
    checks++;
    if (frames !== f0 + 1 || cap_data !== 8'h55 || cap_fe !== 1'b1 || cap_brk !== 1'b0) begin
      failures++;
      $display("FAIL framing_55 got frames=%0d data=%h fe=%b brk=%b exp 1 55 1 0", frames - f0, cap_data, cap_fe, cap_brk);
    end
    f0 = frames;
    rx = 0;
    repeat (20 * CPB) tick();
    checks++;
    if (frames !== f0 + 1 || cap_data !== 8'h00 || cap_fe !== 1'b1 || cap_brk !== 1'b1) begin
      failures++;
      $display("FAIL break_frame got frames=%0d data=%h fe=%b brk=%b exp 1 00 1 1", frames - f0, cap_data, cap_fe, cap_brk);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL break_wait_busy got=%b exp 1", busy);
    end
    rx = 1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || frames !== f0 + 1) begin
      failures++;
      $display("FAIL break_release got busy=%b frames=%0d exp 0 1", busy, frames - f0);
    end
    send_frame(8'h81, 0, 0, 1, -1);
    checks++;
    if (frames !== f0 + 2 || cap_data !== 8'h81 || cap_fe !== 1'b0 || cap_brk !== 1'b0) begin
      failures++;
      $display("FAIL after_break_81 got frames=%0d data=%h fe=%b brk=%b exp 2 81 0 0", frames - f0, cap_data, cap_fe, cap_brk);
    end
  endtask

  task automatic test_overrun();
    int f0 = frames;
    ready = 0;
    send_frame(8'h11, 0, 0, 1, -1);
    send_frame(8'h22, 0, 0, 1, -1);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11 || ovr !== 1'b1 || frames !== f0) begin
      failures++;
      $display("FAIL overrun_hold got valid=%b data=%h ovr=%b frames=%0d exp 1 11 1 0", valid, data, ovr, frames - f0);
    end
    ready = 1;
    tick();
    ready = 0;
    checks++;
    if (valid !== 1'b0 || frames !== f0 + 1 || cap_data !== 8'h11) begin
      failures++;
      $display("FAIL overrun_accept got valid=%b frames=%0d data=%h exp 0 1 11", valid, frames - f0, cap_data);
    end
    checks++;
    if (ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b exp 1", ovr);
    end
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (ovr !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp 0", ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] part = 8'h33;
    int f0;
    ready = 0;
    send_frame(8'h5A, 0, 0, 1, -1);
    checks++;
    if (valid !== 1'b1 || data !== 8'h5A) begin
      failures++;
      $display("FAIL held_5a got valid=%b data=%h exp 1 5a", valid, data);
    end
    send_bit(1'b0, -1);
    for (int b = 0; b < 4; b++) send_bit(part[b], -1);
    rx = part[4];
    repeat (8) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_busy got=%b exp 1", busy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({valid, data, fe, pe, brk, ovr, busy} !== 14'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {valid, data, fe, pe, brk, ovr, busy});
    end
    rx = 1; ready = 1;
    repeat (5) tick();
    rst_n = 1;
    repeat (10) tick();
    f0 = frames;
    send_frame(8'hF0, 0, 0, 1, -1);
    checks++;
    if (frames !== f0 + 1 || cap_data !== 8'hF0 || {cap_fe, cap_pe, cap_brk} !== 3'b0) begin
      failures++;
      $display("FAIL post_reset_f0 got frames=%0d data=%h flags=%b exp 1 f0 000", frames - f0, cap_data, {cap_fe, cap_pe, cap_brk});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_framing_break();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
